// File: rtl/rpn_pkg.sv
// Shared opcode constants and FSM state encoding for the RPN evaluator.
package rpn_pkg;

  localparam int unsigned OP_ADD = 0;
  localparam int unsigned OP_SUB = 1;
  localparam int unsigned OP_AND = 2;
  localparam int unsigned OP_OR  = 3;
  localparam int unsigned OP_XOR = 4;
  localparam int unsigned OP_MUL = 5;
  localparam int unsigned OP_OUT = 7;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 3'd0,
    S_PUSH  = 3'd1,
    S_POP_B = 3'd2,
    S_POP_A = 3'd3,
    S_CALC  = 3'd4,
    S_EMIT  = 3'd5
  } state_t;

endpackage

// File: rtl/rpn_eval_if.sv
// Token, stack and result signals of the RPN evaluator.
// master = token source / stack owner side, slave = evaluator side.
interface rpn_eval_if #(
  parameter int unsigned WIDTH = 4
);

  logic             tok_valid;
  logic             tok_ready;
  logic             tok_is_op;
  logic [WIDTH-1:0] tok_data;
  logic             stk_push;
  logic             stk_pop;
  logic [WIDTH-1:0] stk_din;
  logic [WIDTH-1:0] stk_dout;
  logic             res_valid;
  logic [WIDTH-1:0] res_data;
  logic             err_ovf;
  logic             err_udf;

  modport master (
    output tok_valid, tok_is_op, tok_data, stk_dout,
    input  tok_ready, stk_push, stk_pop, stk_din,
           res_valid, res_data, err_ovf, err_udf
  );

  modport slave (
    input  tok_valid, tok_is_op, tok_data, stk_dout,
    output tok_ready, stk_push, stk_pop, stk_din,
           res_valid, res_data, err_ovf, err_udf
  );

endinterface

// File: rtl/rpn_alu.sv
// Combinational ALU for the RPN evaluator: result = a <op> b, modulo 2^WIDTH.
// op_ok flags a supported binary opcode. MUL is built only when
// RPN_EVAL_MUL_EN is defined; otherwise opcode 5 reports op_ok = 0.
module rpn_alu
  import rpn_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             op_ok
);

  // Opcode decode and arithmetic; a is the deeper stack operand.
  always_comb begin
    result = '0;
    op_ok  = 1'b1;
    case (op)
      WIDTH'(OP_ADD): result = a + b;
      WIDTH'(OP_SUB): result = a - b;
      WIDTH'(OP_AND): result = a & b;
      WIDTH'(OP_OR):  result = a | b;
      WIDTH'(OP_XOR): result = a ^ b;
`ifdef RPN_EVAL_MUL_EN
      WIDTH'(OP_MUL): result = a * b;
`endif
      default:        op_ok  = 1'b0;
    endcase
  end

endmodule

// File: rtl/rpn_eval.sv
// RPN evaluator driving an external registered stack.
// Operands are pushed, binary opcodes pop B then A and push A op B,
// OUT pops the top onto res_data. Overflow/underflow are tracked with an
// internal depth counter and reported through sticky flags.
// Optional MUL support is selected by RPN_EVAL_MUL_EN inside rpn_alu.
module rpn_eval
  import rpn_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input logic       clk,
  input logic       rst,
  rpn_eval_if.slave bus
);

  localparam int unsigned       DEPTH_W   = $clog2(DEPTH + 1);
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(DEPTH);

  state_t             state_q;
  state_t             state_d;
  logic [DEPTH_W-1:0] depth_q;
  logic [WIDTH-1:0]   op_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   din_q;
  logic               ovf_q;
  logic               udf_q;

  logic [WIDTH-1:0]   alu_op;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_ok;
  logic               accept;
  logic               out_tok;
  logic               ovf_hit;
  logic               udf_hit;

  // Token classification at the accept edge.
  assign accept  = bus.tok_valid && (state_q == S_IDLE);
  assign out_tok = bus.tok_is_op && (bus.tok_data == WIDTH'(OP_OUT));
  assign ovf_hit = accept && !bus.tok_is_op && (depth_q == DEPTH_MAX);
  assign udf_hit = accept && bus.tok_is_op &&
                   (out_tok ? (depth_q == '0)
                            : (!alu_ok || (depth_q < DEPTH_W'(2))));

  // The ALU validates the incoming opcode in IDLE and computes in CALC.
  assign alu_op = (state_q == S_IDLE) ? bus.tok_data : op_q;

  rpn_alu #(.WIDTH(WIDTH)) u_alu (
    .op     (alu_op),
    .a      (bus.stk_dout),
    .b      (b_q),
    .result (alu_res),
    .op_ok  (alu_ok)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept && !ovf_hit && !udf_hit)
          state_d = bus.tok_is_op ? S_POP_B : S_PUSH;
      end
      S_PUSH:  state_d = S_IDLE;
      S_POP_B: state_d = (op_q == WIDTH'(OP_OUT)) ? S_EMIT : S_POP_A;
      S_POP_A: state_d = S_CALC;
      S_CALC:  state_d = S_PUSH;
      S_EMIT:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: opcode/B capture, push data, depth and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      depth_q <= '0;
      op_q    <= '0;
      b_q     <= '0;
      din_q   <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      if (accept) op_q <= bus.tok_data;
      if (accept && !bus.tok_is_op && !ovf_hit) din_q <= bus.tok_data;
      if (state_q == S_POP_A) b_q <= bus.stk_dout;
      if (state_q == S_CALC) din_q <= alu_res;
      if (state_q == S_PUSH)
        depth_q <= depth_q + DEPTH_W'(1);
      else if ((state_q == S_POP_B) || (state_q == S_POP_A))
        depth_q <= depth_q - DEPTH_W'(1);
      if (ovf_hit) ovf_q <= 1'b1;
      if (udf_hit) udf_q <= 1'b1;
    end
  end

  // Output decode from the state register and datapath registers.
  always_comb begin
    bus.tok_ready = (state_q == S_IDLE);
    bus.stk_push  = (state_q == S_PUSH);
    bus.stk_pop   = (state_q == S_POP_B) || (state_q == S_POP_A);
    bus.stk_din   = din_q;
    bus.res_valid = (state_q == S_EMIT);
    bus.res_data  = (state_q == S_EMIT) ? bus.stk_dout : '0;
    bus.err_ovf   = ovf_q;
    bus.err_udf   = udf_q;
  end

endmodule
